// File: rtl/processing_pkg.sv
// Shared opcodes, FSM states and decode enums for the multicycle core.
package processing_pkg;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_D   = 3'b011;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  typedef enum logic [2:0] {
    FETCH, DECODE, EXEC, MEM, WB, TRAP
  } state_t;

  typedef enum logic [1:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR
  } alu_op_t;

  typedef enum logic [1:0] {
    IMM_I, IMM_S, IMM_B
  } imm_kind_t;

  function automatic imm_kind_t imm_kind(logic [6:0] op);
    imm_kind_t k;
    k = IMM_I;
    if (op == OP_ST) k = IMM_S;
    if (op == OP_BR) k = IMM_B;
    return k;
  endfunction

endpackage

// File: rtl/processing_mc_imm_gen.sv
// Sign-extended immediate selected by opcode (I, S or B format).
module imm_gen
  import processing_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [31:0]     ir,
  output logic [XLEN-1:0] imm
);

  imm_kind_t kind;
  logic      unused_ir;

  assign kind      = imm_kind(ir[6:0]);
  assign unused_ir = ^ir[19:12];

  always_comb begin
    imm = {{(XLEN-12){ir[31]}}, ir[31:20]};
    unique case (kind)
      IMM_S: imm = {{(XLEN-12){ir[31]}}, ir[31:25], ir[11:7]};
      IMM_B: imm = {{(XLEN-13){ir[31]}}, ir[31], ir[7],
                    ir[30:25], ir[11:8], 1'b0};
      default: ;
    endcase
  end

endmodule

// File: rtl/processing_mc.sv
// Multicycle RV64I-subset core: fetch/decode/exec/mem/wb FSM
// with req/ack memory ports, hardwired x0 and a terminal trap.
module processing_mc
  import processing_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_ack,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic [31:0]     instruction_out,
  output logic            retired,
  output logic            trapped
);

  state_t          state;
  logic [PC_W-1:0] pc, pc_old;
  logic [31:0]     ir;
  logic [XLEN-1:0] a, b, alu_out, mdr;
  logic [XLEN-1:0] rf [1:31];

  logic [6:0]      opcode, f7;
  logic [4:0]      rd, rs1, rs2;
  logic [2:0]      f3;
  logic [XLEN-1:0] imm, ra, rb, alu_res;
  logic            is_r, is_imm, is_ld, is_st, is_br;
  logic            legal, taken, br_trap;
  alu_op_t         alu_op;

  assign opcode = ir[6:0];
  assign rd     = ir[11:7];
  assign f3     = ir[14:12];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];
  assign f7     = ir[31:25];

  assign is_r   = opcode == OP_R;
  assign is_imm = opcode == OP_IMM;
  assign is_ld  = opcode == OP_LD;
  assign is_st  = opcode == OP_ST;
  assign is_br  = opcode == OP_BR;

  imm_gen #(.XLEN(XLEN)) u_imm (
    .ir  (ir),
    .imm (imm)
  );

  assign ra = (rs1 == 5'd0) ? '0 : rf[rs1];
  assign rb = (rs2 == 5'd0) ? '0 : rf[rs2];

  always_comb begin
    legal  = 1'b0;
    alu_op = ALU_ADD;
    unique case (1'b1)
      is_r: begin
        legal = (f7 == F7_BASE &&
                 (f3 == F3_ADD || f3 == F3_AND || f3 == F3_OR)) ||
                (f7 == F7_SUB && f3 == F3_ADD);
        if (f7 == F7_SUB)      alu_op = ALU_SUB;
        else if (f3 == F3_AND) alu_op = ALU_AND;
        else if (f3 == F3_OR)  alu_op = ALU_OR;
      end
      is_imm: legal = f3 == F3_ADD;
      is_ld:  legal = f3 == F3_D;
      is_st:  legal = f3 == F3_D;
      is_br:  legal = f3 == F3_BEQ || f3 == F3_BNE;
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    alu_res = a + b;
    unique case (alu_op)
      ALU_SUB: alu_res = a - b;
      ALU_AND: alu_res = a & b;
      ALU_OR:  alu_res = a | b;
      default: ;
    endcase
  end

  assign taken   = (f3 == F3_BNE) ? (a != b) : (a == b);
  // A taken branch to a non-word-aligned target traps instead of retiring.
  assign br_trap = taken && alu_out[1];

  assign imem_req        = reset && state == FETCH;
  assign dmem_req        = reset && state == MEM;
  assign imem_addr       = pc;
  assign dmem_we         = is_st;
  assign dmem_addr       = alu_out;
  assign dmem_wdata      = b;
  assign instruction_out = ir;
  assign trapped         = reset && state == TRAP;
  assign retired         = reset &&
    ((state == WB) ||
     (state == MEM && is_st && dmem_ack) ||
     (state == EXEC && is_br && !br_trap));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= FETCH;
      pc      <= RESET_PC;
      pc_old  <= '0;
      ir      <= '0;
      a       <= '0;
      b       <= '0;
      alu_out <= '0;
      mdr     <= '0;
      for (int i = 1; i < 32; i++) rf[i] <= '0;
    end else begin
      unique case (state)
        FETCH: if (imem_ack) begin
          ir     <= imem_rdata;
          pc_old <= pc;
          pc     <= pc + PC_W'(4);
          state  <= DECODE;
        end
        DECODE: begin
          a       <= ra;
          b       <= rb;
          alu_out <= XLEN'(pc_old) + imm;
          state   <= legal ? EXEC : TRAP;
        end
        EXEC: begin
          unique case (1'b1)
            is_r: begin
              alu_out <= alu_res;
              state   <= WB;
            end
            is_imm: begin
              alu_out <= a + imm;
              state   <= WB;
            end
            is_ld || is_st: begin
              alu_out <= a + imm;
              state   <= MEM;
            end
            is_br: begin
              if (br_trap) state <= TRAP;
              else begin
                if (taken) pc <= alu_out[PC_W-1:0];
                state <= FETCH;
              end
            end
            default: state <= TRAP;
          endcase
        end
        MEM: if (dmem_ack) begin
          if (!is_st) mdr <= dmem_rdata;
          state <= is_st ? FETCH : WB;
        end
        WB: begin
          if (rd != 5'd0) rf[rd] <= is_ld ? mdr : alu_out;
          state <= FETCH;
        end
        default: state <= TRAP;
      endcase
    end
  end

endmodule
